// File: rtl/gol_pkg.sv
// Shared types, sizes and helpers for the gol grid display path.
package gol_pkg;

    localparam int unsigned GRID_W    = 64;
    localparam int unsigned ROWS      = 8;
    localparam int unsigned COLS      = 8;
    localparam int unsigned ROW_IDX_W = $clog2(ROWS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SCAN  = 2'd2,
        BLANK = 2'd3
    } scan_state_t;

    // Row 0 is the top byte of the grid word; bit 7 of each row is the leftmost column.
    function automatic logic [COLS-1:0] row_of(input logic [GRID_W-1:0]    grid,
                                               input logic [ROW_IDX_W-1:0] r);
        return COLS'(grid >> (COLS * (ROWS - 1 - 32'(r))));
    endfunction

endpackage

// File: rtl/gol_tick_counter.sv
// Saturating up-counter with synchronous clear and a terminal-count compare against i_term.
module gol_tick_counter #(
    parameter int unsigned MAX = 1,
    parameter int unsigned W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    input  logic [W-1:0] i_term,
    output logic         o_tc_c
);

    logic [W-1:0] r_cnt;

    // Holds at MAX rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != W'(MAX))) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_tc_c = (r_cnt == i_term);

endmodule

// File: rtl/gol_matrix_scan.sv
// Row-scans a shadow copy of the gol grid onto an 8x8 LED matrix and paces generation steps.
module gol_matrix_scan
    import gol_pkg::*;
#(
    parameter int unsigned ROW_DWELL      = 1000,
    parameter int unsigned BLANK_CYC      = 2,
    parameter int unsigned FRAMES_PER_GEN = 60
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [GRID_W-1:0] grid_in,
    input  logic              grid_valid,
    output logic              grid_ready,
    output logic [ROWS-1:0]   row_en,
    output logic [COLS-1:0]   col_data,
    output logic              frame_done,
    output logic              gen_tick
);

    localparam int unsigned DW_MAX = (ROW_DWELL > BLANK_CYC) ? ROW_DWELL : BLANK_CYC;
    localparam int unsigned DW_W   = $clog2(DW_MAX + 1);
    localparam int unsigned FC_W   = $clog2(FRAMES_PER_GEN + 1);

    localparam logic [DW_W-1:0]      SCAN_TERM  = DW_W'(ROW_DWELL - 1);
    localparam logic [DW_W-1:0]      BLANK_TERM = DW_W'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);
    localparam logic [FC_W-1:0]      FRAME_TERM = FC_W'(FRAMES_PER_GEN - 1);
    localparam logic [ROW_IDX_W-1:0] LAST_ROW   = ROW_IDX_W'(ROWS - 1);

    scan_state_t          r_state;
    scan_state_t          w_state_nx;
    logic [GRID_W-1:0]    r_shadow;
    logic [GRID_W-1:0]    w_shadow_nx;
    logic [ROW_IDX_W-1:0] r_row_idx;
    logic [ROW_IDX_W-1:0] w_row_idx_nx;
    logic [ROWS-1:0]      r_row_en;
    logic [ROWS-1:0]      w_row_en_nx;
    logic [COLS-1:0]      r_col_data;
    logic [COLS-1:0]      w_col_data_nx;
    logic                 r_grid_ready;
    logic                 r_frame_done;
    logic                 r_gen_tick;
    logic                 w_frame_done_nx;
    logic                 w_gen_tick_nx;
    logic                 w_row_end;

    logic                 w_dwell_clr;
    logic                 w_dwell_inc;
    logic                 w_dwell_tc;
    logic [DW_W-1:0]      w_dwell_term;
    logic                 w_frame_clr;
    logic                 w_frame_inc;
    logic                 w_frame_tc;

    // One counter times both the lit and the blank phase of a row.
    assign w_dwell_term = (r_state == BLANK) ? BLANK_TERM : SCAN_TERM;

    gol_tick_counter #(
        .MAX    (DW_MAX)
    ) u_dwell (
        .clk    (clk),
        .rst_n  (reset_n),
        .i_clr  (w_dwell_clr),
        .i_inc  (w_dwell_inc),
        .i_term (w_dwell_term),
        .o_tc_c (w_dwell_tc)
    );

    gol_tick_counter #(
        .MAX    (FRAMES_PER_GEN)
    ) u_frame (
        .clk    (clk),
        .rst_n  (reset_n),
        .i_clr  (w_frame_clr),
        .i_inc  (w_frame_inc),
        .i_term (FRAME_TERM),
        .o_tc_c (w_frame_tc)
    );

    // Next-state, counter control and next output values.
    always_comb begin
        w_state_nx      = r_state;
        w_shadow_nx     = r_shadow;
        w_row_idx_nx    = r_row_idx;
        w_dwell_clr     = 1'b1;
        w_dwell_inc     = 1'b0;
        w_frame_clr     = 1'b0;
        w_frame_inc     = 1'b0;
        w_frame_done_nx = 1'b0;
        w_gen_tick_nx   = 1'b0;
        w_row_end       = 1'b0;

        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_nx = LOAD;
                end
            end
            LOAD: begin
                if (grid_valid) begin
                    w_shadow_nx = grid_in;
                end
                w_row_idx_nx = '0;
                w_state_nx   = SCAN;
            end
            SCAN: begin
                if (w_dwell_tc) begin
                    if (BLANK_CYC == 0) begin
                        w_row_end = 1'b1;
                    end else begin
                        w_state_nx = BLANK;
                    end
                end else begin
                    w_dwell_clr = 1'b0;
                    w_dwell_inc = 1'b1;
                end
            end
            BLANK: begin
                if (w_dwell_tc) begin
                    w_row_end = 1'b1;
                end else begin
                    w_dwell_clr = 1'b0;
                    w_dwell_inc = 1'b1;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase

        // enable only matters here, so a frame always finishes once started.
        if (w_row_end) begin
            if (r_row_idx != LAST_ROW) begin
                w_row_idx_nx = r_row_idx + ROW_IDX_W'(1);
                w_state_nx   = SCAN;
            end else begin
                w_frame_done_nx = 1'b1;
                if (w_frame_tc) begin
                    w_gen_tick_nx = 1'b1;
                    w_frame_clr   = 1'b1;
                end else begin
                    w_frame_inc = 1'b1;
                end
                w_state_nx = enable ? LOAD : IDLE;
            end
        end

        w_row_en_nx   = '0;
        w_col_data_nx = '0;
        if (w_state_nx == SCAN) begin
            w_row_en_nx   = ROWS'(1) << w_row_idx_nx;
            w_col_data_nx = row_of(w_shadow_nx, w_row_idx_nx);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Outputs are registered from next-state values so they line up with r_state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow     <= '0;
            r_row_idx    <= '0;
            r_row_en     <= '0;
            r_col_data   <= '0;
            r_grid_ready <= 1'b0;
            r_frame_done <= 1'b0;
            r_gen_tick   <= 1'b0;
        end else begin
            r_shadow     <= w_shadow_nx;
            r_row_idx    <= w_row_idx_nx;
            r_row_en     <= w_row_en_nx;
            r_col_data   <= w_col_data_nx;
            r_grid_ready <= (w_state_nx == LOAD);
            r_frame_done <= w_frame_done_nx;
            r_gen_tick   <= w_gen_tick_nx;
        end
    end

    assign grid_ready = r_grid_ready;
    assign row_en     = r_row_en;
    assign col_data   = r_col_data;
    assign frame_done = r_frame_done;
    assign gen_tick   = r_gen_tick;

endmodule
